// File: rtl/tick_timer_bank_if.sv
// Command, flag-clear and readback bus for tick_timer_bank.
// The game-logic master drives commands. The timer bank slave returns the selected channel count.
interface tick_timer_bank_if #(
  parameter int N_CH = 4,
  parameter int CW   = 16
);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            cmd_start;
  logic            cmd_stop;
  logic [IW-1:0]   cmd_ch;
  logic [CW-1:0]   cmd_period;
  logic            cmd_mode;
  logic [N_CH-1:0] flag_clr;
  logic [IW-1:0]   rd_ch;
  logic [CW-1:0]   rd_count;

  modport master (
    output cmd_start, cmd_stop, cmd_ch, cmd_period, cmd_mode, flag_clr, rd_ch,
    input  rd_count
  );

  modport slave (
    input  cmd_start, cmd_stop, cmd_ch, cmd_period, cmd_mode, flag_clr, rd_ch,
    output rd_count
  );
endinterface

// File: rtl/tick_timer_bank.sv
// Shared mclk prescaler plus N_CH programmable base-tick down-counters.
// Each channel raises one-cycle expire pulses and sticky flags, in one-shot or periodic mode.
module tick_timer_bank #(
  parameter int DIV  = 100000,
  parameter int N_CH = 4,
  parameter int CW   = 16
) (
  input  logic            mclk,
  input  logic            rst,
  tick_timer_bank_if.slave bus,
  output logic            base_tick,
  output logic [N_CH-1:0] expire,
  output logic [N_CH-1:0] flags,
  output logic [N_CH-1:0] running,
  output logic            irq
);
  localparam int PW = $clog2(DIV);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PW-1:0]   pre_cnt;
  logic [CW-1:0]   count  [N_CH];
  logic [CW-1:0]   period [N_CH];
  logic [N_CH-1:0] mode;

  logic [N_CH-1:0] start_hit;
  logic [N_CH-1:0] stop_hit;
  logic [N_CH-1:0] exp_nxt;
  logic [N_CH-1:0] flags_nxt;

  // A command addressed to a channel suppresses that channel's tick this cycle.
  // A cmd_ch value outside the channel range matches no channel.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    start_hit = '0;
    stop_hit  = '0;
    exp_nxt   = '0;
    for (int i = 0; i < N_CH; i++) begin
      start_hit[i] = bus.cmd_start && (bus.cmd_ch == IW'(i));
      stop_hit[i]  = bus.cmd_stop  && (bus.cmd_ch == IW'(i));
      exp_nxt[i]   = running[i] && base_tick && !start_hit[i] && !stop_hit[i]
                     && (count[i] == CW'(1));
    end
    // A flag set wins over a clear in the same cycle, so no event is lost.
    flags_nxt = (flags & ~bus.flag_clr) | exp_nxt;
  end

  always_comb begin
    bus.rd_count = '0;
    for (int i = 0; i < N_CH; i++)
      if (bus.rd_ch == IW'(i)) bus.rd_count = count[i];
  end

  always_ff @(posedge mclk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      pre_cnt   <= '0;
      base_tick <= 1'b0;
      expire    <= '0;
      flags     <= '0;
      irq       <= 1'b0;
      running   <= '0;
      mode      <= '0;
      // NOTE: these per-channel arrays are small register files, not RAM. They are reset so readback is 0.
      for (int i = 0; i < N_CH; i++) begin
        count[i]  <= '0;
        period[i] <= '0;
      end
    end else begin
      if (pre_cnt == PW'(DIV - 1)) begin
        pre_cnt   <= '0;
        base_tick <= 1'b1;
      end else begin
        pre_cnt   <= pre_cnt + PW'(1);
        base_tick <= 1'b0;
      end

      expire <= exp_nxt;
      flags  <= flags_nxt;
      irq    <= |flags_nxt;

      for (int i = 0; i < N_CH; i++) begin
        if (start_hit[i]) begin
          if (bus.cmd_period != '0) begin
            count[i]   <= bus.cmd_period;
            period[i]  <= bus.cmd_period;
            mode[i]    <= bus.cmd_mode;
            running[i] <= 1'b1;
          end else begin
            count[i]   <= '0;
            running[i] <= 1'b0;
          end
        end else if (stop_hit[i]) begin
          running[i] <= 1'b0;
        end else if (running[i] && base_tick) begin
          if (exp_nxt[i]) begin
            if (mode[i]) begin
              count[i] <= period[i];
            end else begin
              count[i]   <= '0;
              running[i] <= 1'b0;
            end
          end else if (count[i] > CW'(1)) begin
            count[i] <= count[i] - CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tick_timer_bank.sv
// Self-checking bench for tick_timer_bank: directed scenarios plus randomized commands.
// A cycle-level behavioural model is compared against every DUT output on every cycle.
module tb_tick_timer_bank;
  localparam int DIV  = 4;
  localparam int N_CH = 5;
  localparam int CW   = 16;

  logic            mclk = 1'b0;
  logic            rst  = 1'b1;
  logic            base_tick;
  logic            irq;
  logic [N_CH-1:0] expire;
  logic [N_CH-1:0] flags;
  logic [N_CH-1:0] running;

  tick_timer_bank_if #(.N_CH(N_CH), .CW(CW)) bus ();

  tick_timer_bank #(.DIV(DIV), .N_CH(N_CH), .CW(CW)) dut (
    .mclk      (mclk),
    .rst       (rst),
    .bus       (bus),
    .base_tick (base_tick),
    .expire    (expire),
    .flags     (flags),
    .running   (running),
    .irq       (irq)
  );

  always #5 mclk = ~mclk;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model. m_since counts edges since reset release, so a base tick falls on every multiple of DIV.
  int              m_since;
  bit              m_bt;
  int              m_cnt [N_CH];
  int              m_per [N_CH];
  logic [N_CH-1:0] m_mode, m_run, m_flag, m_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic [N_CH-1:0] e;
    bit st, sp;
    e = '0;
    if (rst) begin
      m_since = 0; m_bt = 0;
      m_mode = '0; m_run = '0; m_flag = '0; m_exp = '0;
      for (int i = 0; i < N_CH; i++) begin m_cnt[i] = 0; m_per[i] = 0; end
      return;
    end
    for (int i = 0; i < N_CH; i++) begin
      st = bus.cmd_start && (int'(bus.cmd_ch) == i);
      sp = bus.cmd_stop  && (int'(bus.cmd_ch) == i);
      if (st) begin
        if (bus.cmd_period != 0) begin
          m_cnt[i] = int'(bus.cmd_period); m_per[i] = int'(bus.cmd_period);
          m_mode[i] = bus.cmd_mode; m_run[i] = 1'b1;
        end else begin
          m_cnt[i] = 0; m_run[i] = 1'b0;
        end
      end else if (sp) begin
        m_run[i] = 1'b0;
      end else if (m_run[i] && m_bt) begin
        if (m_cnt[i] == 1) begin
          e[i] = 1'b1;
          if (m_mode[i]) m_cnt[i] = m_per[i];
          else begin m_cnt[i] = 0; m_run[i] = 1'b0; end
        end else if (m_cnt[i] > 1) begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
    m_flag = (m_flag & ~bus.flag_clr) | e;
    m_exp  = e;
    m_since++;
    m_bt = (m_since % DIV == 0);
  endtask

  task automatic compare();
    int exp_rd;
    exp_rd = (int'(bus.rd_ch) < N_CH) ? m_cnt[bus.rd_ch] : 0;
    check("base_tick", 32'(base_tick), 32'(m_bt));
    check("expire",    32'(expire),    32'(m_exp));
    check("flags",     32'(flags),     32'(m_flag));
    check("irq",       32'(irq),       32'(|m_flag));
    check("running",   32'(running),   32'(m_run));
    check("rd_count",  32'(bus.rd_count), 32'(exp_rd));
  endtask

  task automatic tick();
    model_step();
    @(posedge mclk);
    #1;
    compare();
  endtask

  task automatic clear_cmd();
    bus.cmd_start = 0; bus.cmd_stop = 0; bus.cmd_ch = '0;
    bus.cmd_period = '0; bus.cmd_mode = 0;
  endtask

  task automatic cmd(input bit st, input bit sp, input int ch, input int per, input bit md);
    bus.cmd_start = st; bus.cmd_stop = sp; bus.cmd_ch = 3'(ch);
    bus.cmd_period = CW'(per); bus.cmd_mode = md;
    tick();
    clear_cmd();
  endtask

  // Counts base ticks observed from the start edge until the channel expires, with a cycle budget.
  task automatic wait_exp(input int ch, input int budget, output int n);
    bit seen;
    n = int'(base_tick);
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (expire[ch]) seen = 1;
      else n += int'(base_tick);
    end
    if (!seen) check("expire_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    bit found;
    clear_cmd();
    bus.flag_clr = '0;
    bus.rd_ch    = '0;

    // Reset state.
    rst = 1;
    repeat (3) tick();
    check("rst_base_tick", 32'(base_tick), 32'd0);
    check("rst_flags",     32'(flags),     32'd0);
    check("rst_running",   32'(running),   32'd0);
    check("rst_rd_count",  32'(bus.rd_count), 32'd0);

    // Base tick pulses after edges 4, 8, 12 following release.
    rst = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("bt_edge", 32'(base_tick), 32'((k % 4) == 0));
    end

    // One-shot channel 0 with period 3, then clear its flag.
    bus.rd_ch = 3'd0;
    cmd(1, 0, 0, 3, 0);
    wait_exp(0, 40, n);
    check("oneshot_ticks", 32'(n), 32'd3);
    check("oneshot_flag",  32'(flags[0]), 32'd1);
    check("oneshot_irq",   32'(irq), 32'd1);
    tick();
    check("oneshot_run",   32'(running[0]), 32'd0);
    bus.flag_clr = 5'b00001;
    tick();
    bus.flag_clr = '0;
    check("clr_flag", 32'(flags[0]), 32'd0);
    check("clr_irq",  32'(irq), 32'd0);

    // Periodic channel 1 with period 2, clear held on its flag, stopped after the third tick.
    bus.rd_ch = 3'd1;
    bus.flag_clr = 5'b00010;
    cmd(1, 0, 1, 2, 1);
    n = int'(base_tick);
    for (int k = 0; k < 60 && n < 3; k++) begin
      tick();
      if (expire[1]) check("set_beats_clr", 32'(flags[1]), 32'd1);
      n += int'(base_tick);
    end
    tick();
    check("periodic_count", 32'(bus.rd_count), 32'd1);
    cmd(0, 1, 1, 0, 0);
    check("stop_run", 32'(running[1]), 32'd0);
    repeat (3 * DIV) tick();
    check("stop_frozen", 32'(bus.rd_count), 32'd1);
    bus.flag_clr = '0;

    // Start in a base-tick cycle: that tick is skipped.
    bus.rd_ch = 3'd2;
    found = 0;
    for (int k = 0; k < 2 * DIV && !found; k++) begin
      if (base_tick) found = 1;
      else tick();
    end
    check("bt_found", 32'(found), 32'd1);
    cmd(1, 0, 2, 1, 0);
    check("bt_start_noexp", 32'(expire[2]), 32'd0);
    check("bt_start_count", 32'(bus.rd_count), 32'd1);
    wait_exp(2, 40, n);
    check("bt_start_ticks", 32'(n), 32'd1);

    // Simultaneous start and stop, then commands to nonexistent channels.
    cmd(1, 1, 3, 5, 1);
    check("start_wins", 32'(running), 32'b01000);
    cmd(1, 0, 7, 9, 1);
    cmd(1, 1, 5, 2, 0);
    check("bad_ch_run", 32'(running), 32'b01000);
    bus.rd_ch = 3'd7;
    tick();
    check("bad_rd_ch", 32'(bus.rd_count), 32'd0);

    // Zero period stops a running channel without an expire.
    bus.rd_ch = 3'd3;
    cmd(1, 0, 3, 0, 1);
    check("zero_run",   32'(running[3]), 32'd0);
    check("zero_count", 32'(bus.rd_count), 32'd0);
    repeat (3 * DIV) tick();

    // Reset in the middle of a countdown.
    cmd(1, 0, 0, 4, 1);
    cmd(1, 0, 4, 2, 0);
    repeat (6) tick();
    bus.rd_ch = 3'd0;
    rst = 1;
    tick();
    check("midrst_out", 32'({base_tick, expire, flags, running, irq}), 32'd0);
    check("midrst_rd",  32'(bus.rd_count), 32'd0);
    rst = 0;

    // Randomized commands, flag clears, readback selects and occasional resets.
    for (int k = 0; k < 2500; k++) begin
      bus.cmd_start  = ($urandom_range(0, 7) == 0);
      bus.cmd_stop   = ($urandom_range(0, 15) == 0);
      bus.cmd_ch     = 3'($urandom_range(0, 7));
      bus.cmd_period = CW'($urandom_range(0, 5));
      bus.cmd_mode   = 1'($urandom());
      bus.flag_clr   = ($urandom_range(0, 3) == 0) ? N_CH'($urandom()) : '0;
      bus.rd_ch      = 3'($urandom_range(0, 7));
      rst            = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0;
    clear_cmd();
    bus.flag_clr = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
